// File: rtl/serv_bufreg2_seq_if.sv
// Core request/completion handshake and data-bus lines of the bufreg2 sequencer.
// The slave side is the sequencer; the master side is the core plus data bus.
interface serv_bufreg2_seq_if;
   logic       i_req;
   logic       o_ready;
   logic [1:0] i_op;
   logic [1:0] i_size;
   logic [1:0] i_lsb;
   logic       o_done;
   logic       o_err;
   logic       i_dbus_ack;
   logic       o_dbus_cyc;
   logic       o_dbus_we;
   logic [3:0] o_dbus_sel;

   modport master (
      output i_req, i_op, i_size, i_lsb, i_dbus_ack,
      input  o_ready, o_done, o_err, o_dbus_cyc, o_dbus_we, o_dbus_sel
   );

   modport slave (
      input  i_req, i_op, i_size, i_lsb, i_dbus_ack,
      output o_ready, o_done, o_err, o_dbus_cyc, o_dbus_we, o_dbus_sel
   );
endinterface

// File: rtl/serv_bufreg2_seq.sv
// Sequencer for the SERV bit-serial buffer register: serial init, bus transaction or
// shift countdown, serial readout, then a one-cycle completion pulse.
module serv_bufreg2_seq #(
   parameter int unsigned TIMEOUT = 0
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   serv_bufreg2_seq_if.slave  bus,
   input  logic               i_sh_done,
   output logic               o_init,
   output logic               o_en,
   output logic               o_cnt_done,
   output logic               o_byte_valid,
   output logic               o_load,
   output logic               o_shift_op,
   output logic [1:0]         o_lsb,
   output logic [4:0]         o_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_BUS,
      S_SHIFT,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [1:0] OP_STORE = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_SHIFT = 2'b10;
   localparam logic [1:0] OP_NOP   = 2'b11;

   localparam int unsigned     WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [1:0]        op_q, op_d;
   logic [1:0]        size_q, size_d;
   logic [1:0]        lsb_q, lsb_d;
   logic              err_q, err_d;

   logic              in_idle, in_init, in_bus, in_shift, in_run, in_done;
   logic              cnt_last;
   logic              wd_expire;
   logic [3:0]        sel_mask;
   logic              store_bv;

   assign in_idle  = (state_q == S_IDLE);
   assign in_init  = (state_q == S_INIT);
   assign in_bus   = (state_q == S_BUS);
   assign in_shift = (state_q == S_SHIFT);
   assign in_run   = (state_q == S_RUN);
   assign in_done  = (state_q == S_DONE);
   assign cnt_last = (cnt_q == 5'd31);

   // The watchdog counter wraps harmlessly when TIMEOUT is 0; only the compare is gated.
   assign wd_expire = (TIMEOUT != 0) && (wd_q == WD_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wd_d    = wd_q;
      op_d    = op_q;
      size_d  = size_q;
      lsb_d   = lsb_q;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.i_req) begin
               op_d    = bus.i_op;
               size_d  = bus.i_size;
               lsb_d   = bus.i_lsb;
               cnt_d   = 5'd0;
               state_d = (bus.i_op == OP_NOP) ? S_DONE : S_INIT;
            end
         end
         S_INIT: begin
            cnt_d = cnt_q + 5'd1;
            wd_d  = '0;
            if (cnt_last) begin
               state_d = (op_q == OP_SHIFT) ? S_SHIFT : S_BUS;
            end
         end
         S_BUS: begin
            if (bus.i_dbus_ack) begin
               state_d = (op_q == OP_LOAD) ? S_RUN : S_DONE;
            end else if (wd_expire) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         S_SHIFT: begin
            if (i_sh_done) begin
               state_d = S_RUN;
            end else if (wd_expire) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         wd_q    <= '0;
         op_q    <= 2'b00;
         size_q  <= 2'b00;
         lsb_q   <= 2'b00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wd_q    <= wd_d;
         op_q    <= op_d;
         size_q  <= size_d;
         lsb_q   <= lsb_d;
         err_q   <= err_d;
      end
   end

   // Store byte lanes: byte index is cnt[4:3]; word covers all, half the low two, byte the first.
   always_comb begin
      store_bv = 1'b0;
      if (size_q[1]) begin
         store_bv = 1'b1;
      end else if (size_q[0]) begin
         store_bv = ~cnt_q[4];
      end else begin
         store_bv = (cnt_q[4:3] == 2'b00);
      end
   end

   always_comb begin
      sel_mask = 4'b1111;
      if (op_q == OP_STORE) begin
         if (size_q[1]) begin
            sel_mask = 4'b1111;
         end else if (size_q[0]) begin
            sel_mask = 4'b0011;
         end else begin
            sel_mask = 4'b0001;
         end
      end
   end

   assign bus.o_ready      = in_idle;
   assign bus.o_done       = in_done;
   assign bus.o_err        = err_q;
   assign bus.o_dbus_cyc   = in_bus;
   assign bus.o_dbus_we    = in_bus & (op_q == OP_STORE);
   assign bus.o_dbus_sel   = in_bus ? (sel_mask << lsb_q) : 4'b0000;

   assign o_init       = in_init;
   assign o_en         = in_init | in_run;
   assign o_cnt        = cnt_q;
   assign o_cnt_done   = (in_init | in_run) & cnt_last;
   assign o_byte_valid = (in_init | in_run) & ((op_q != OP_STORE) | store_bv);
   assign o_load       = in_bus & (op_q == OP_LOAD) & bus.i_dbus_ack;
   assign o_shift_op   = (op_q == OP_SHIFT) & (in_init | in_shift | in_run);
   assign o_lsb        = in_idle ? 2'b00 : lsb_q;

endmodule

// File: tb/tb_serv_bufreg2_seq.sv
// Bench for serv_bufreg2_seq: two instances (watchdog off and TIMEOUT=8) share one stimulus
// stream and are checked every cycle against an expected per-cycle output timeline.
module tb_serv_bufreg2_seq;

   localparam logic [21:0] IDLE_V = 22'h200000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sh_done;
   always #5 clk = ~clk;

   serv_bufreg2_seq_if if0 ();
   serv_bufreg2_seq_if if8 ();

   logic       init0, en0, cd0, bv0, ld0, sop0;
   logic [1:0] lsb0;
   logic [4:0] cnt0;
   logic       init8, en8, cd8, bv8, ld8, sop8;
   logic [1:0] lsb8;
   logic [4:0] cnt8;

   serv_bufreg2_seq #(.TIMEOUT(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(if0), .i_sh_done(sh_done),
      .o_init(init0), .o_en(en0), .o_cnt_done(cd0), .o_byte_valid(bv0),
      .o_load(ld0), .o_shift_op(sop0), .o_lsb(lsb0), .o_cnt(cnt0)
   );

   serv_bufreg2_seq #(.TIMEOUT(8)) dut8 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(if8), .i_sh_done(sh_done),
      .o_init(init8), .o_en(en8), .o_cnt_done(cd8), .o_byte_valid(bv8),
      .o_load(ld8), .o_shift_op(sop8), .o_lsb(lsb8), .o_cnt(cnt8)
   );

   logic [21:0] obs0, obs8;
   assign obs0 = {if0.o_ready, init0, en0, cd0, bv0, ld0, sop0, lsb0, cnt0,
                  if0.o_done, if0.o_err, if0.o_dbus_cyc, if0.o_dbus_we, if0.o_dbus_sel};
   assign obs8 = {if8.o_ready, init8, en8, cd8, bv8, ld8, sop8, lsb8, cnt8,
                  if8.o_done, if8.o_err, if8.o_dbus_cyc, if8.o_dbus_we, if8.o_dbus_sel};

   int checks = 0;
   int errors = 0;
   logic [21:0] mq[$];
   logic [21:0] q0[$];
   logic [21:0] q8[$];

   function automatic logic [21:0] vec(logic rdy, logic ini, logic en, logic cd, logic bv,
                                       logic ld, logic sop, logic [1:0] lsb, logic [4:0] cnt,
                                       logic dn, logic er, logic cyc, logic we, logic [3:0] sel);
      return {rdy, ini, en, cd, bv, ld, sop, lsb, cnt, dn, er, cyc, we, sel};
   endfunction

   // Expected output of every cycle from the accept cycle through the DONE pulse,
   // assuming the ack / sh_done pulse arrives dly cycles after the wait phase starts.
   function automatic void model(int tmo, logic [1:0] op, logic [1:0] size, logic [1:0] lsb, int dly);
      logic sh, acked, bv;
      int   nwait, m;
      logic [3:0] sel;
      mq.delete();
      mq.push_back(IDLE_V);
      if (op == 2'd3) begin
         mq.push_back(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lsb, 5'd0,
                          1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
         return;
      end
      sh = (op == 2'd2);
      for (int k = 0; k < 32; k++) begin
         bv = (op != 2'd0) || size[1] || (size == 2'd1 && k < 16) || (size == 2'd0 && k < 8);
         mq.push_back(vec(1'b0, 1'b1, 1'b1, k == 31, bv, 1'b0, sh, lsb, 5'(k),
                          1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
      end
      acked = (tmo == 0) || (dly < tmo);
      nwait = acked ? dly + 1 : tmo;
      m = (op == 2'd0) ? (size[1] ? 15 : (size[0] ? 3 : 1)) : 15;
      sel = 4'((m * (1 << lsb)) % 16);
      for (int w = 0; w < nwait; w++) begin
         if (sh)
            mq.push_back(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, lsb, 5'd0,
                             1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
         else
            mq.push_back(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, acked && w == dly && op == 2'd1,
                             1'b0, lsb, 5'd0, 1'b0, 1'b0, 1'b1, op == 2'd0, sel));
      end
      if (acked && op != 2'd0) begin
         for (int k = 0; k < 32; k++)
            mq.push_back(vec(1'b0, 1'b0, 1'b1, k == 31, 1'b1, 1'b0, sh, lsb, 5'(k),
                             1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
      end
      mq.push_back(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lsb, 5'd0,
                       1'b1, !acked, 1'b0, 1'b0, 4'd0));
   endfunction

   task automatic check(string tag, logic [21:0] obs, logic [21:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(logic req, logic [1:0] op, logic [1:0] size, logic [1:0] lsb,
                        logic ack, logic sh);
      if0.i_req = req;   if8.i_req = req;
      if0.i_op = op;     if8.i_op = op;
      if0.i_size = size; if8.i_size = size;
      if0.i_lsb = lsb;   if8.i_lsb = lsb;
      if0.i_dbus_ack = ack; if8.i_dbus_ack = ack;
      sh_done = sh;
   endtask

   // Called just after a rising edge. hold = last cycle the request stays asserted
   // (inside INIT, so it must be ignored); abort_at >= 0 resets asynchronously there.
   task automatic run_op(string name, logic [1:0] op, logic [1:0] size, logic [1:0] lsb,
                         int dly, int hold, int abort_at);
      logic req, ack, sh;
      logic [1:0] dop, dsz, dlsb;
      int gap;
      model(0, op, size, lsb, dly); q0 = mq;
      model(8, op, size, lsb, dly); q8 = mq;
      while (q0.size() < q8.size()) q0.push_back(IDLE_V);
      while (q8.size() < q0.size()) q8.push_back(IDLE_V);
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) begin
         q0.push_back(IDLE_V);
         q8.push_back(IDLE_V);
      end
      for (int i = 0; i < q0.size(); i++) begin
         req = (i <= hold);
         if (i == 0) begin
            dop = op; dsz = size; dlsb = lsb;
         end else begin
            dop = 2'($urandom); dsz = 2'($urandom); dlsb = 2'($urandom);
         end
         ack = 1'($urandom);
         sh  = 1'($urandom);
         if (op != 2'd3 && i >= 33 && i <= 33 + dly) begin
            if (op == 2'd2) sh = (i == 33 + dly);
            else            ack = (i == 33 + dly);
         end
         drive(req, dop, dsz, dlsb, ack, sh);
         @(negedge clk);
         check($sformatf("%s t0 c%0d", name, i), obs0, q0[i]);
         check($sformatf("%s t8 c%0d", name, i), obs8, q8[i]);
         if (i == abort_at) begin
            #1 rst_n = 1'b0;
            #1;
            check({name, " async_rst t0"}, obs0, IDLE_V);
            check({name, " async_rst t8"}, obs8, IDLE_V);
            @(posedge clk);
            #1;
            check({name, " held_rst t0"}, obs0, IDLE_V);
            check({name, " held_rst t8"}, obs8, IDLE_V);
            rst_n = 1'b1;
            drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
            return;
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [1:0] rop, rsz, rlsb;
      drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset t0", obs0, IDLE_V);
      check("reset t8", obs8, IDLE_V);
      @(posedge clk);
      #1 rst_n = 1'b1;

      run_op("st_word",   2'd0, 2'd2, 2'd0, 0, 0, -1);
      run_op("st_byte",   2'd0, 2'd0, 2'd3, 3, 12, -1);
      run_op("st_half",   2'd0, 2'd1, 2'd1, 1, 30, -1);
      run_op("load",      2'd1, 2'd3, 2'd2, 2, 5, -1);
      run_op("shift",     2'd2, 2'd1, 2'd1, 7, 20, -1);
      run_op("load_tmo",  2'd1, 2'd0, 2'd3, 11, 0, -1);
      run_op("shift_tmo", 2'd2, 2'd0, 2'd2, 9, 0, -1);
      run_op("st_tmo",    2'd0, 2'd2, 2'd1, 8, 0, -1);
      run_op("nop",       2'd3, 2'd1, 2'd2, 0, 0, -1);
      run_op("rst_run",   2'd1, 2'd0, 2'd1, 0, 0, 45);
      run_op("st_post",   2'd0, 2'd1, 2'd2, 1, 0, -1);

      for (int n = 0; n < 30; n++) begin
         rop  = 2'($urandom);
         rsz  = 2'($urandom);
         rlsb = 2'($urandom);
         run_op($sformatf("rnd%0d", n), rop, rsz, rlsb, int'($urandom_range(0, 12)),
                (rop == 2'd3) ? 0 : int'($urandom_range(0, 30)), -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
